// File: rtl/sb_rx_msg_queue.sv
// Sideband receive message queue: buffers decoded SB messages with payloads and
// delivers them to the LTSM blocks one per request pulse, dropping retransmitted duplicates.
module sb_rx_msg_queue #(
    parameter int DEPTH = 4,
    parameter bit DEDUP = 1'b1,
    parameter int MSG_W = 8
) (
    input  logic                     clk_100MHz,
    input  logic                     reset_n,
    input  logic [MSG_W-1:0]         wr_msg_i,
    input  logic [63:0]              wr_data_i,
    input  logic                     wr_valid_i,
    input  logic                     flush_i,
    input  logic                     SB_RX_msg_req_i,
    output logic [MSG_W-1:0]         SB_RX_msg_o,
    output logic [63:0]              SB_RX_dataBus_o,
    output logic                     SB_RX_msg_valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_cnt_o
);

    // state      | meaning
    // ST_IDLE    | no delivery this cycle, a request may pop the head
    // ST_DELIVER | head is on the outputs with the valid pulse high
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_DELIVER = 1'b1;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [MSG_W-1:0] mem_msg  [DEPTH];
    logic [63:0]      mem_data [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [MSG_W-1:0] newest_msg;
    logic [63:0]      newest_data;
    logic [0:0]       state;
    logic [0:0]       state_nxt;

    logic is_full;
    logic is_empty;
    logic is_dup;
    logic do_push;
    logic do_drop;
    logic do_pop;

    // Dup and full decisions use the registered count so a same-cycle pop never changes them.
    always_comb begin
        is_full  = (count == FULL_CNT);
        is_empty = (count == '0);
        is_dup   = DEDUP && !is_empty
                   && (wr_msg_i == newest_msg) && (wr_data_i == newest_data);
        do_push  = wr_valid_i && !flush_i && !is_full && !is_dup;
        do_drop  = wr_valid_i && !flush_i && is_full && !is_dup;
        do_pop   = SB_RX_msg_req_i && !flush_i && !is_empty && (state == ST_IDLE);
    end

    always_comb begin
        count_nxt = count;
        if (flush_i) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        if (!flush_i && do_pop) begin
            state_nxt = ST_DELIVER;
        end
    end

    // Entry storage carries no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk_100MHz) begin
        if (do_push) begin
            mem_msg[wr_ptr]  <= wr_msg_i;
            mem_data[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty_o     <= 1'b1;
            full_o      <= 1'b0;
            newest_msg  <= '0;
            newest_data <= '0;
            state       <= ST_IDLE;
        end else begin
            count   <= count_nxt;
            empty_o <= (count_nxt == '0);
            full_o  <= (count_nxt == FULL_CNT);
            state   <= state_nxt;
            if (flush_i) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                newest_msg  <= '0;
                newest_data <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr      <= wr_ptr + PW'(1);
                    newest_msg  <= wr_msg_i;
                    newest_data <= wr_data_i;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Delivery registers hold the popped entry for exactly the pulse cycle, zero otherwise.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            SB_RX_msg_o     <= '0;
            SB_RX_dataBus_o <= '0;
        end else if (do_pop) begin
            SB_RX_msg_o     <= mem_msg[rd_ptr];
            SB_RX_dataBus_o <= mem_data[rd_ptr];
        end else begin
            SB_RX_msg_o     <= '0;
            SB_RX_dataBus_o <= '0;
        end
    end

    // Loss flags survive flush so the LTSM can still see that messages were dropped.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (do_drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 8'hFF) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

    assign SB_RX_msg_valid_o = (state == ST_DELIVER);
    assign count_o           = count;

endmodule
